// File: rtl/mul_share_arb.sv
// Two-requester arbiter sharing one 26x24 unsigned multiplier in a 2-stage pipeline.
// Define MUL_SHARE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.

module wallace_26x24 (
    input  logic [25:0] a_i,
    input  logic [23:0] b_i,
    output logic [49:0] z_o
);
    logic [49:0] s, c, pp, t;

    // Carry-save reduction of the partial products, one carry-propagate add at the end.
    // Carries past bit 49 are discarded safely because the true product fits in 50 bits.
    always_comb begin
        s  = '0;
        c  = '0;
        pp = '0;
        t  = '0;
        for (int i = 0; i < 24; i++) begin
            pp = b_i[i] ? (50'(a_i) << i) : 50'd0;
            t  = s ^ c ^ pp;
            c  = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
        end
        z_o = s + c;
    end
endmodule

module mul_share_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [25:0] req0_a,
    input  logic [23:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [25:0] req1_a,
    input  logic [23:0] req1_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_id,
    output logic [49:0] out_z
);
    logic        s1_valid_q, s1_valid_d;
    logic        s1_id_q, s1_id_d;
    logic [25:0] s1_a_q, s1_a_d;
    logic [23:0] s1_b_q, s1_b_d;
    logic        s2_valid_q, s2_valid_d;
    logic        s2_id_q, s2_id_d;
    logic [49:0] s2_z_q, s2_z_d;
    logic        s2_free, s1_free, s1_adv;
    logic        gnt_vld, gnt_id, req_hs;
    logic [49:0] prod;
`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
    logic        last_grant_q, last_grant_d;
`endif

    wallace_26x24 u_mul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .z_o (prod)
    );

    assign s2_free = !s2_valid_q || out_ready;
    assign s1_free = !s1_valid_q || s2_free;
    assign s1_adv  = s1_valid_q && s2_free;

    always_comb begin
        gnt_vld = req0_valid || req1_valid;
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
        gnt_id  = !req0_valid;
`else
        gnt_id  = (req0_valid && req1_valid) ? !last_grant_q : !req0_valid;
`endif
    end

    assign req_hs     = gnt_vld && s1_free && !rst;
    assign req0_ready = req_hs && !gnt_id;
    assign req1_ready = req_hs && gnt_id;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_z_d     = s2_z_q;
        if (req_hs) begin
            s1_valid_d = 1'b1;
            s1_id_d    = gnt_id;
            s1_a_d     = gnt_id ? req1_a : req0_a;
            s1_b_d     = gnt_id ? req1_b : req0_b;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_id_d    = s1_id_q;
            s2_z_d     = prod;
        end else if (s2_valid_q && out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
    assign last_grant_d = req_hs ? gnt_id : last_grant_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
`ifndef MUL_SHARE_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Data registers carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        s1_id_q <= s1_id_d;
        s1_a_q  <= s1_a_d;
        s1_b_q  <= s1_b_d;
        s2_id_q <= s2_id_d;
        s2_z_q  <= s2_z_d;
    end

    assign out_valid = s2_valid_q;
    assign out_id    = s2_id_q;
    assign out_z     = s2_z_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized + directed bench for mul_share_arb against an in-order queue model.
module tb_mul_share_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [25:0] req0_a, req1_a;
    logic [23:0] req0_b, req1_b;
    logic        out_valid, out_ready, out_id;
    logic [49:0] out_z;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int ndel = 0;
    int nacc = 0;

    typedef struct {
        logic        id;
        logic [49:0] z;
        int          acc;
    } item_t;
    item_t q[$];
    int    last_m = 1;

    always #5 clk = ~clk;

    mul_share_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_z      (out_z)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: capacity two, a product is visible two cycles after acceptance, strictly in order.
    task automatic step();
        logic  exp_ov, ok, gv, g;
        item_t it;
        @(negedge clk);
        exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("out_id", 64'(out_id), 64'(q[0].id));
            chk("out_z", 64'(out_z), 64'(q[0].z));
        end
        ok = !rst && (q.size() < 2 || out_ready);
        gv = req0_valid || req1_valid;
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
        g  = !req0_valid;
`else
        if (req0_valid && req1_valid) g = (last_m == 0);
        else                          g = !req0_valid;
`endif
        chk("req0_ready", 64'(req0_ready), 64'(ok && gv && !g));
        chk("req1_ready", 64'(req1_ready), 64'(ok && gv && g));
        if (rst) begin
            q.delete();
            last_m = 1;
        end else begin
            if (exp_ov && out_ready) begin
                void'(q.pop_front());
                ndel++;
            end
            if (ok && gv) begin
                it.id  = g;
                it.z   = g ? 50'(req1_a) * 50'(req1_b) : 50'(req0_a) * 50'(req0_b);
                it.acc = cyc;
                q.push_back(it);
                last_m = g ? 1 : 0;
                nacc++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [25:0] a0, input logic [23:0] b0,
                         input logic v1, input logic [25:0] a1, input logic [23:0] b1,
                         input logic ordy);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        out_ready  = ordy;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (2) step();
        rst = 1'b0;
        step();
        // single request 3*5
        drive(1, 26'd3, 24'd5, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) step();
        // maximum operands from requester 1
        drive(0, 0, 0, 1, 26'h3FFFFFF, 24'hFFFFFF, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) step();
        // contention for four cycles
        for (int i = 0; i < 4; i++) begin
            drive(1, 26'(100 + i), 24'(7 + i), 1, 26'(200 + i), 24'(11 + i), 1);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) step();
        // backpressure: out_ready low for three cycles from cycle 2
        for (int i = 0; i < 8; i++) begin
            drive(i < 6, 26'(1000 + 17 * i), 24'(33 + i), 0, 0, 0, !(i >= 2 && i < 5));
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (4) step();
        // reset with products in flight
        drive(1, 26'd9, 24'd9, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 1, 26'd12, 24'd12, 1);
        step();
        rst = 1'b1;
        drive(1, 26'd1, 24'd1, 1, 26'd2, 24'd2, 1);
        step();
        rst = 1'b0;
        drive(1, 26'd21, 24'd2, 1, 26'd5, 24'd5, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) step();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 26'h3FFFFFF : 26'($urandom),
                  ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom),
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 26'h3FFFFFF : 26'($urandom),
                  ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom),
                  $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (5) step();
        chk("drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mul_share_arb.md
MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 Parameters: none; the design is fixed at two requesters and 26x24 operands.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req0_valid  in  1  requester 0 operand pair valid.
REQ-005 req0_ready  out  1  requester 0 pair accepted this cycle when high with req0_valid.
REQ-006 req0_a / req0_b  in  26 / 24  requester 0 unsigned multiplicand / multiplier.
REQ-007 req1_valid, req1_ready, req1_a[25:0], req1_b[23:0]: same meaning for requester 1.
REQ-008 out_valid  out  1  product valid.
REQ-009 out_ready  in  1  consumer accepts product.
REQ-010 out_id  out  1  index of the requester that issued the product.
REQ-011 out_z  out  50  unsigned product a*b.

Function
REQ-012 The block shall share one wallace_26x24 instance between the two requesters, in a 2-stage pipeline: S1 = registered operands + id, S2 = registered product + id.
REQ-013 A request handshake occurs when reqN_valid && reqN_ready; an output handshake occurs when out_valid && out_ready.
REQ-014 s2_free = !s2_valid || out_ready; s1_free = !s1_valid || s2_free.
REQ-015 At most one reqN_ready shall be high per cycle, only for the granted requester, and only when s1_free; reqN_ready shall not depend on reqN_valid of the other requester except through arbitration.
REQ-016 Arbitration: only one valid, grant it; both valid, grant the requester not equal to last_grant; neither valid, no grant.
REQ-017 last_grant shall update to the granted id only on a request handshake; stalls (s1_free low) shall not change it.
REQ-018 S1 loads on handshake; S1 clears (s1_valid=0) when it advances into S2 with no new handshake.
REQ-019 S2 loads {id, a*b} from S1 when s1_valid && s2_free; S2 clears on an output handshake with no S1 advance.
REQ-020 Latency: request handshake at cycle N -> out_valid at cycle N+2 when out_ready held high; throughput one product per cycle.
REQ-021 Backpressure: while out_valid && !out_ready, out_valid, out_id, out_z shall hold stable and the pipeline shall hold at most 2 products; no product is dropped or duplicated.
REQ-022 Products shall emerge in acceptance order; out_z shall equal the full 50-bit unsigned product with no truncation.
REQ-023 Simultaneous output handshake and new request handshake in one cycle shall both take effect (pipeline shifts).

Reset
REQ-024 On rst high at a clock edge: s1_valid=0, s2_valid=0, out_valid=0, last_grant=1 (requester 0 wins the first contention); data registers need not reset, out_z/out_id don't-care while out_valid=0.
REQ-025 Reset mid-operation shall discard in-flight products; req0_ready and req1_ready shall be 0 in any cycle rst is high.

Configuration
REQ-026 Macro MUL_SHARE_ARB_FIXED_PRIO_EN: when defined, arbitration shall be fixed priority (requester 0 always wins contention; last_grant unused); when undefined, round-robin per REQ-016/017 applies.

Verification
REQ-027 Single request: req0 a=3, b=5, out_ready=1 -> out_valid at +2 cycles, out_z=15, out_id=0.
REQ-028 Max operands: req1 a=0x3FFFFFF, b=0xFFFFFF -> out_z=0x3FFFFFB000001, out_id=1.
REQ-029 Contention: both valid continuously for 4 cycles, round-robin build -> grants 0,1,0,1 and out_id sequence 0,1,0,1; FIXED_PRIO build -> 0,0,0,0 and req1_ready stays 0.
REQ-030 Backpressure: stream 4 requests, out_ready=0 from cycle 2 for 3 cycles -> out_valid/out_z held stable, reqN_ready low once 2 products buffered, all 4 products delivered in order after release.
REQ-031 Reset mid-flight: 2 requests accepted, rst pulsed one cycle -> out_valid=0 next cycle, no stale product emerges, next request after reset yields correct product at +2 with req0 winning contention.
